axi_lite_cmd_master: RTL and testbench

AXI_LITE_CMD_MASTER -- requirements
Module: axi_lite_cmd_master

---
 rtl/axi_lite_cmd_master.sv | 144 ++++++++++++++
 tb/tb_axi_lite_cmd_master.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite command master: converts one simple read/write command into a single
// AXI4-Lite transaction and returns its completion; one transaction outstanding.
//
// state          | meaning
// S_IDLE         | waiting for a command, cmd_ready high
// S_WR_ADDR_DATA | AW and W channels in flight, each dropped after its own handshake
// S_WR_RESP      | bready high, waiting for bvalid
// S_RD_ADDR      | arvalid high, waiting for arready
// S_RD_DATA      | rready high, waiting for rvalid
// S_RESP         | rsp_valid high, waiting for rsp_ready
module axi_lite_cmd_master #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,

    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [2:0]            awprot,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [31:0]           wdata,
    output logic [3:0]            wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,

    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [2:0]            arprot,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [31:0]           rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready
);

    localparam logic [2:0] S_IDLE         = 3'd0;
    localparam logic [2:0] S_WR_ADDR_DATA = 3'd1;
    localparam logic [2:0] S_WR_RESP      = 3'd2;
    localparam logic [2:0] S_RD_ADDR      = 3'd3;
    localparam logic [2:0] S_RD_DATA      = 3'd4;
    localparam logic [2:0] S_RESP         = 3'd5;

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;
    logic [1:0]            resp_q;
    logic                  aw_pend;
    logic                  w_pend;
    logic                  aw_clear;
    logic                  w_clear;

    // A channel counts as finished if it already completed or completes this edge.
    assign aw_clear = !aw_pend || awready;
    assign w_clear  = !w_pend  || wready;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            resp_q  <= '0;
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        addr_q <= cmd_addr;
                        if (cmd_write) begin
                            wdata_q <= cmd_wdata;
                            aw_pend <= 1'b1;
                            w_pend  <= 1'b1;
                            state   <= S_WR_ADDR_DATA;
                        end else begin
                            state <= S_RD_ADDR;
                        end
                    end
                end
                S_WR_ADDR_DATA: begin
                    if (awready) aw_pend <= 1'b0;
                    if (wready)  w_pend  <= 1'b0;
                    if (aw_clear && w_clear) state <= S_WR_RESP;
                end
                S_WR_RESP: begin
                    if (bvalid) begin
                        rdata_q <= '0;
                        resp_q  <= bresp;
                        state   <= S_RESP;
                    end
                end
                S_RD_ADDR: begin
                    if (arready) state <= S_RD_DATA;
                end
                S_RD_DATA: begin
                    if (rvalid) begin
                        rdata_q <= rdata;
                        resp_q  <= rresp;
                        state   <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // cmd_ready is held low for as long as reset is asserted.
    assign cmd_ready = aresetn && (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;

    assign awaddr  = addr_q;
    assign awprot  = 3'b000;
    assign awvalid = aw_pend;
    assign wdata   = wdata_q;
    assign wstrb   = 4'hF;
    assign wvalid  = w_pend;
    assign bready  = (state == S_WR_RESP);

    assign araddr  = addr_q;
    assign arprot  = 3'b000;
    assign arvalid = (state == S_RD_ADDR);
    assign rready  = (state == S_RD_DATA);

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: a behavioural AXI4-Lite memory slave with tunable
// wait states plus a word-array reference model of the expected completions.
`timescale 1ns/1ps
module tb_axi_lite_cmd_master;
    localparam int AW = 4;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [31:0]   cmd_wdata = '0;
    logic          cmd_ready;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, wvalid, bready, arvalid, rready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]    bresp = 2'b00, rresp = 2'b00;
    logic [31:0]   rdata = '0;

    int n_checks = 0;
    int n_fail = 0;

    // slave knobs and expectations, set by the test tasks
    int            aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
    logic [1:0]    sl_bresp = 2'b00, sl_rresp = 2'b00;
    logic [AW-1:0] exp_addr = '0;
    logic [31:0]   exp_wdata = '0;
    int            aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    logic [31:0]   smem [16];
    logic [31:0]   ref_mem [16];

    axi_lite_cmd_master #(.ADDR_WIDTH(AW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Slave: everything happens on the falling edge, so any handshake decided here
    // takes place at the following rising edge.
    int            aw_age = 0, w_age = 0, b_age = 0, ar_age = 0, r_age = 0;
    logic          aw_done = 0, w_done = 0, ar_done = 0;
    logic [AW-1:0] s_awaddr = '0, s_araddr = '0;
    logic [31:0]   s_wdata = '0;
    logic          aw_wait = 0, w_wait = 0, ar_wait = 0, aw_drop = 0, w_drop = 0, ar_drop = 0;
    logic [AW-1:0] hold_awaddr = '0, hold_araddr = '0;
    logic [31:0]   hold_wdata = '0;

    always @(negedge aclk) begin
        if (!aresetn) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            bresp = 0; rresp = 0; rdata = 0;
            aw_done = 0; w_done = 0; ar_done = 0;
            aw_age = 0; w_age = 0; b_age = 0; ar_age = 0; r_age = 0;
            aw_wait = 0; w_wait = 0; ar_wait = 0; aw_drop = 0; w_drop = 0; ar_drop = 0;
        end else begin
            if (aw_wait) begin
                n_checks++;
                if (awvalid !== 1'b1 || awaddr !== hold_awaddr) begin
                    n_fail++;
                    $display("FAIL aw_hold: awvalid=%b awaddr=%h, required 1 and %h", awvalid, awaddr, hold_awaddr);
                end
            end
            if (w_wait) begin
                n_checks++;
                if (wvalid !== 1'b1 || wdata !== hold_wdata) begin
                    n_fail++;
                    $display("FAIL w_hold: wvalid=%b wdata=%h, required 1 and %h", wvalid, wdata, hold_wdata);
                end
            end
            if (ar_wait) begin
                n_checks++;
                if (arvalid !== 1'b1 || araddr !== hold_araddr) begin
                    n_fail++;
                    $display("FAIL ar_hold: arvalid=%b araddr=%h, required 1 and %h", arvalid, araddr, hold_araddr);
                end
            end
            if (aw_drop || w_drop || ar_drop) begin
                n_checks++;
                if ((aw_drop && awvalid !== 1'b0) || (w_drop && wvalid !== 1'b0) || (ar_drop && arvalid !== 1'b0)) begin
                    n_fail++;
                    $display("FAIL valid_drop: awvalid=%b wvalid=%b arvalid=%b after handshake, required 0",
                             awvalid, wvalid, arvalid);
                end
            end
            n_checks++;
            if (bready !== (aw_done && w_done) || rready !== ar_done) begin
                n_fail++;
                $display("FAIL ready_window: bready=%b rready=%b, required %b %b",
                         bready, rready, aw_done && w_done, ar_done);
            end

            aw_age  = awvalid ? aw_age + 1 : 0;
            awready = awvalid && (aw_age > aw_lat);
            w_age   = wvalid ? w_age + 1 : 0;
            wready  = wvalid && (w_age > w_lat);
            ar_age  = arvalid ? ar_age + 1 : 0;
            arready = arvalid && (ar_age > ar_lat);
            b_age   = (aw_done && w_done) ? b_age + 1 : 0;
            bvalid  = aw_done && w_done && (b_age > b_lat);
            bresp   = bvalid ? sl_bresp : 2'b00;
            r_age   = ar_done ? r_age + 1 : 0;
            rvalid  = ar_done && (r_age > r_lat);
            rdata   = rvalid ? smem[s_araddr] : 32'h0;
            rresp   = rvalid ? sl_rresp : 2'b00;

            aw_wait = awvalid && !awready;  hold_awaddr = awaddr;
            w_wait  = wvalid && !wready;    hold_wdata  = wdata;
            ar_wait = arvalid && !arready;  hold_araddr = araddr;
            aw_drop = awvalid && awready;
            w_drop  = wvalid && wready;
            ar_drop = arvalid && arready;

            if (awvalid && awready) begin
                aw_hs++; aw_done = 1; s_awaddr = awaddr; aw_age = 0;
                n_checks++;
                if (awaddr !== exp_addr || awprot !== 3'b000) begin
                    n_fail++;
                    $display("FAIL aw_beat: awaddr=%h awprot=%b, required %h 000", awaddr, awprot, exp_addr);
                end
            end
            if (wvalid && wready) begin
                w_hs++; w_done = 1; s_wdata = wdata; w_age = 0;
                n_checks++;
                if (wdata !== exp_wdata || wstrb !== 4'hF) begin
                    n_fail++;
                    $display("FAIL w_beat: wdata=%h wstrb=%h, required %h F", wdata, wstrb, exp_wdata);
                end
            end
            if (arvalid && arready) begin
                ar_hs++; ar_done = 1; s_araddr = araddr; ar_age = 0;
                n_checks++;
                if (araddr !== exp_addr || arprot !== 3'b000) begin
                    n_fail++;
                    $display("FAIL ar_beat: araddr=%h arprot=%b, required %h 000", araddr, arprot, exp_addr);
                end
            end
            if (bvalid && bready) begin
                b_hs++; smem[s_awaddr] = s_wdata; aw_done = 0; w_done = 0;
            end
            if (rvalid && rready) begin
                r_hs++; ar_done = 0;
            end
        end
    end

    // Runs one command from a falling edge to the falling edge after its response
    // handshake. lat = cycles from the cmd handshake cycle to first rsp_valid.
    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [31:0] d, input int hold,
                         output logic [31:0] rd, output logic [1:0] rs, output int lat, output int acc);
        logic [31:0] rd0;
        logic [1:0]  rs0;
        rd = '0; rs = '0; lat = -1; acc = 0;
        exp_addr = a; exp_wdata = d;
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        while (cmd_ready !== 1'b1 && acc < 100) begin
            @(negedge aclk);
            acc++;
        end
        if (cmd_ready !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL cmd_accept_timeout: cmd_ready=%b, required 1", cmd_ready);
            cmd_valid = 0;
            return;
        end
        @(negedge aclk);
        cmd_valid = 0; cmd_addr = AW'($urandom); cmd_wdata = $urandom; cmd_write = 1'($urandom);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 300) begin
            @(negedge aclk);
            lat++;
        end
        if (rsp_valid !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL rsp_timeout: rsp_valid=%b, required 1", rsp_valid);
            return;
        end
        rd0 = rsp_rdata; rs0 = rsp_resp;
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL cmd_ready_in_resp: cmd_ready=%b, required 0", cmd_ready);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge aclk);
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== rd0 || rsp_resp !== rs0 || cmd_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL rsp_hold: valid=%b rdata=%h resp=%b cmd_ready=%b, required 1 %h %b 0",
                         rsp_valid, rsp_rdata, rsp_resp, cmd_ready, rd0, rs0);
            end
        end
        rsp_ready = 1;
        @(negedge aclk);
        rsp_ready = 0;
        n_checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rsp_release: rsp_valid=%b cmd_ready=%b, required 0 1", rsp_valid, cmd_ready);
        end
        rd = rd0; rs = rs0;
    endtask

    task automatic test_reset();
        aresetn = 0;
        repeat (3) @(negedge aclk);
        n_checks++;
        if ({cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: ready/valid bits=%b, required 0000000",
                     {cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready});
        end
        n_checks++;
        if (awaddr !== '0 || araddr !== '0 || wdata !== '0 || rsp_rdata !== '0 || rsp_resp !== '0) begin
            n_fail++;
            $display("FAIL reset_data: awaddr=%h araddr=%h wdata=%h rdata=%h resp=%b, required all 0",
                     awaddr, araddr, wdata, rsp_rdata, rsp_resp);
        end
        n_checks++;
        if (awprot !== 3'b000 || arprot !== 3'b000 || wstrb !== 4'hF) begin
            n_fail++;
            $display("FAIL const_outputs: awprot=%b arprot=%b wstrb=%h, required 000 000 F", awprot, arprot, wstrb);
        end
        aresetn = 1;
        @(negedge aclk);
        n_checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: cmd_ready=%b rsp_valid=%b, required 1 0", cmd_ready, rsp_valid);
        end
    endtask

    task automatic test_write_zero_wait();
        logic [31:0] rd; logic [1:0] rs; int lat, acc, b0;
        aw_lat = 0; w_lat = 0; b_lat = 0; sl_bresp = 2'b00;
        b0 = b_hs;
        issue(1'b1, 4'h2, 32'h0000_000F, 0, rd, rs, lat, acc);
        ref_mem[2] = 32'h0000_000F;
        n_checks++;
        if (lat !== 3 || rd !== 32'h0 || rs !== 2'b00 || b_hs - b0 !== 1) begin
            n_fail++;
            $display("FAIL write_zero_wait: lat=%0d rdata=%h resp=%b bhs=%0d, required 3 0 00 1", lat, rd, rs, b_hs - b0);
        end
    endtask

    task automatic test_read();
        logic [31:0] rd; logic [1:0] rs; int lat, acc;
        ar_lat = 0; r_lat = 0; sl_rresp = 2'b00;
        issue(1'b0, 4'h1, 32'h0, 0, rd, rs, lat, acc);
        n_checks++;
        if (rd !== 32'h5 || rs !== 2'b00 || lat !== 3) begin
            n_fail++;
            $display("FAIL read_basic: rdata=%h resp=%b lat=%0d, required 5 00 3", rd, rs, lat);
        end
    endtask

    task automatic test_w_delay();
        logic [31:0] rd; logic [1:0] rs; int lat, acc, a0, w0, b0;
        logic [31:0] d;
        aw_lat = 0; w_lat = 4; b_lat = 0; sl_bresp = 2'b00;
        a0 = aw_hs; w0 = w_hs; b0 = b_hs; d = $urandom;
        issue(1'b1, 4'h9, d, 0, rd, rs, lat, acc);
        ref_mem[9] = d;
        n_checks++;
        if (aw_hs - a0 !== 1 || w_hs - w0 !== 1 || b_hs - b0 !== 1 || lat !== 7) begin
            n_fail++;
            $display("FAIL w_delay: aw=%0d w=%0d b=%0d lat=%0d, required 1 1 1 7", aw_hs - a0, w_hs - w0, b_hs - b0, lat);
        end
        w_lat = 0;
    endtask

    task automatic test_resp_backpressure();
        logic [31:0] rd; logic [1:0] rs; int lat, acc;
        logic [31:0] d;
        aw_lat = 0; w_lat = 0; b_lat = 0; sl_bresp = 2'b10; d = $urandom;
        issue(1'b1, 4'h3, d, 5, rd, rs, lat, acc);
        ref_mem[3] = d;
        n_checks++;
        if (rs !== 2'b10 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL bresp_slverr: resp=%b rdata=%h, required 10 0", rs, rd);
        end
        sl_bresp = 2'b00; sl_rresp = 2'b00;
        issue(1'b0, 4'h3, 32'h0, 0, rd, rs, lat, acc);
        n_checks++;
        if (acc !== 0 || rd !== ref_mem[3] || rs !== 2'b00) begin
            n_fail++;
            $display("FAIL after_backpressure: wait=%0d rdata=%h resp=%b, required 0 %h 00", acc, rd, rs, ref_mem[3]);
        end
    endtask

    task automatic test_reset_in_wr_resp();
        int guard;
        aw_lat = 0; w_lat = 0; b_lat = 50;
        exp_addr = 4'h6; exp_wdata = 32'hDEAD_BEEF;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 4'h6; cmd_wdata = 32'hDEAD_BEEF;
        @(negedge aclk);
        cmd_valid = 0;
        guard = 0;
        while (bready !== 1'b1 && guard < 20) begin
            @(negedge aclk);
            guard++;
        end
        n_checks++;
        if (bready !== 1'b1) begin
            n_fail++;
            $display("FAIL reach_wr_resp: bready=%b, required 1", bready);
        end
        aresetn = 0;
        @(negedge aclk);
        n_checks++;
        if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_mid_txn: aw w ar b r rsp=%b, required 000000",
                     {awvalid, wvalid, arvalid, bready, rready, rsp_valid});
        end
        @(negedge aclk);
        aresetn = 1;
        b_lat = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            n_checks++;
            if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || awvalid !== 1'b0 || wdata !== '0) begin
                n_fail++;
                $display("FAIL post_reset_idle: cmd_ready=%b rsp_valid=%b awvalid=%b wdata=%h, required 1 0 0 0",
                         cmd_ready, rsp_valid, awvalid, wdata);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, d, exp_rd; logic [1:0] rs, exp_rs; int lat, acc, exp_lat, hold;
        logic wr; logic [AW-1:0] a;
        for (int n = 0; n < 40; n++) begin
            wr = 1'($urandom_range(0, 1)); a = AW'($urandom_range(0, 15)); d = $urandom;
            aw_lat = $urandom_range(0, 3); w_lat = $urandom_range(0, 3); b_lat = $urandom_range(0, 3);
            ar_lat = $urandom_range(0, 3); r_lat = $urandom_range(0, 3);
            sl_bresp = 2'($urandom_range(0, 3)); sl_rresp = 2'($urandom_range(0, 3));
            hold = $urandom_range(0, 3);
            if (wr) begin
                exp_rd = 32'h0; exp_rs = sl_bresp;
                exp_lat = 3 + ((aw_lat > w_lat) ? aw_lat : w_lat) + b_lat;
            end else begin
                exp_rd = ref_mem[a]; exp_rs = sl_rresp;
                exp_lat = 3 + ar_lat + r_lat;
            end
            issue(wr, a, d, hold, rd, rs, lat, acc);
            if (wr) ref_mem[a] = d;
            n_checks++;
            if (rd !== exp_rd || rs !== exp_rs || lat !== exp_lat || acc !== 0) begin
                n_fail++;
                $display("FAIL random[%0d] wr=%b a=%h: rdata=%h resp=%b lat=%0d wait=%0d, required %h %b %0d 0",
                         n, wr, a, rd, rs, lat, acc, exp_rd, exp_rs, exp_lat);
            end
        end
        aw_lat = 0; w_lat = 0; b_lat = 0; ar_lat = 0; r_lat = 0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0000_0111;
            smem[i]    = ref_mem[i];
        end
        ref_mem[1] = 32'h0000_0005;
        smem[1]    = 32'h0000_0005;
        test_reset();
        test_read();
        test_write_zero_wait();
        test_w_delay();
        test_resp_backpressure();
        test_reset_in_wr_resp();
        test_random();
        repeat (2) @(negedge aclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
